// File: rtl/kf8259_pkg.sv
// Shared encodings for the 8259 acknowledge/EOI path: ack-state enum, OCW2 commands,
// the 8080 CALL opcode and one-hot/index helpers.
package kf8259_pkg;

   typedef enum logic [1:0] {
      ACK_IDLE = 2'd0,
      ACK_1    = 2'd1,
      ACK_2    = 2'd2,
      ACK_3    = 2'd3
   } ack_state_e;

   // OCW2 {R, SL, EOI}
   localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_NOP          = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
   localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

   localparam logic [7:0] CALL_OPCODE = 8'hCD;

   function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic [7:0] index_to_onehot(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

endpackage

// File: rtl/kf8259_ocw2_decoder.sv
// Combinational OCW2 decode: turns {R,SL,EOI} plus level into a one-hot clear mask,
// an optional priority-rotate update and AEOI-rotate set/clear.
module kf8259_ocw2_decoder
   import kf8259_pkg::*;
(
   input  logic [2:0] cmd_i,
   input  logic [2:0] level_i,
   input  logic [7:0] highest_in_service_i,
   output logic [7:0] eoi_mask_o,
   output logic       rotate_valid_o,
   output logic [2:0] rotate_value_o,
   output logic       aeoi_rotate_set_o,
   output logic       aeoi_rotate_clr_o
);

   always_comb begin
      eoi_mask_o        = '0;
      rotate_valid_o    = 1'b0;
      rotate_value_o    = level_i;
      aeoi_rotate_set_o = 1'b0;
      aeoi_rotate_clr_o = 1'b0;
      case (cmd_i)
         OCW2_NS_EOI: eoi_mask_o = highest_in_service_i;
         OCW2_SP_EOI: eoi_mask_o = index_to_onehot(level_i);
         OCW2_ROT_NS_EOI: begin
            // Nothing in service means nothing cleared, so no rotation either.
            eoi_mask_o     = highest_in_service_i;
            rotate_valid_o = |highest_in_service_i;
            rotate_value_o = onehot_to_index(highest_in_service_i);
         end
         OCW2_ROT_SP_EOI: begin
            eoi_mask_o     = index_to_onehot(level_i);
            rotate_valid_o = 1'b1;
         end
         OCW2_SET_PRI:      rotate_valid_o    = 1'b1;
         OCW2_ROT_AEOI_SET: aeoi_rotate_set_o = 1'b1;
         OCW2_ROT_AEOI_CLR: aeoi_rotate_clr_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/kf8259_acknowledge_control.sv
// INTA sequencer and EOI/rotation control for the 8259 in-service register.
// Define KF8259_MODE_8080_EN to add the three-pulse 8080 CALL sequence (ACK3).
//
// state    | meaning
// ACK_IDLE | no acknowledge in progress
// ACK_1    | first INTA seen, level frozen, in-service set
// ACK_2    | second INTA: 8086 vector / 8080 low address byte
// ACK_3    | third INTA: 8080 high address byte (8080 build only)
module kf8259_acknowledge_control
   import kf8259_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       ack_mode_8086,
   input  logic       auto_eoi,
   input  logic [4:0] vector_base,
   input  logic [2:0] address_low_base,
   input  logic [7:0] address_high,
   input  logic       ack_start,
   input  logic       ack_end,
   input  logic [7:0] interrupt_request,
   input  logic [7:0] highest_level_in_service,
   input  logic       ocw2_valid,
   input  logic [2:0] ocw2_cmd,
   input  logic [2:0] ocw2_level,
   output logic       latch_in_service,
   output logic [7:0] interrupt,
   output logic [7:0] end_of_interrupt,
   output logic [2:0] priority_rotate,
   output logic [7:0] vector_out,
   output logic       vector_oe,
   output logic       ack_busy
);

   ack_state_e state_q, state_d;
   logic       mode_8086_q, mode_8086_d;
   logic       auto_eoi_q, auto_eoi_d;
   logic [7:0] acked_q, acked_d;
   logic       spurious_q, spurious_d;
   logic       rot_aeoi_q, rot_aeoi_d;
   logic       latch_q, latch_d;
   logic [7:0] intr_q, intr_d;
   logic [7:0] eoi_q, eoi_d;
   logic [2:0] rotate_q, rotate_d;
   logic [7:0] vout_q, vout_d;
   logic       voe_q, voe_d;
   logic       aeoi_fire;
   logic       mode_in;
   logic [2:0] level;

   logic [7:0] dec_eoi_mask;
   logic       dec_rot_valid;
   logic [2:0] dec_rot_value;
   logic       dec_aeoi_set;
   logic       dec_aeoi_clr;

`ifdef KF8259_MODE_8080_EN
   assign mode_in = ack_mode_8086;
`else
   logic unused_8080;
   assign mode_in     = 1'b1;
   assign unused_8080 = ^{ack_mode_8086, address_low_base, address_high};
`endif

   assign level = onehot_to_index(acked_q);

   kf8259_ocw2_decoder u_ocw2_decoder (
      .cmd_i                (ocw2_cmd),
      .level_i              (ocw2_level),
      .highest_in_service_i (highest_level_in_service),
      .eoi_mask_o           (dec_eoi_mask),
      .rotate_valid_o       (dec_rot_valid),
      .rotate_value_o       (dec_rot_value),
      .aeoi_rotate_set_o    (dec_aeoi_set),
      .aeoi_rotate_clr_o    (dec_aeoi_clr)
   );

   always_comb begin
      state_d     = state_q;
      mode_8086_d = mode_8086_q;
      auto_eoi_d  = auto_eoi_q;
      acked_d     = acked_q;
      spurious_d  = spurious_q;
      rot_aeoi_d  = rot_aeoi_q;
      latch_d     = 1'b0;
      intr_d      = '0;
      rotate_d    = rotate_q;
      vout_d      = vout_q;
      voe_d       = voe_q;
      aeoi_fire   = 1'b0;
      case (state_q)
         ACK_IDLE: begin
            if (ack_start) begin
               state_d     = ACK_1;
               mode_8086_d = mode_in;
               auto_eoi_d  = auto_eoi;
               spurious_d  = (interrupt_request == 8'h00);
               // A spurious acknowledge behaves as level 7 but never touches in-service.
               acked_d     = (interrupt_request == 8'h00) ? 8'h80 : interrupt_request;
               latch_d     = (interrupt_request != 8'h00);
               intr_d      = interrupt_request;
               voe_d       = ~mode_in;
               vout_d      = mode_in ? 8'h00 : CALL_OPCODE;
            end
         end
         ACK_1: begin
            if (ack_start) begin
               state_d = ACK_2;
               voe_d   = 1'b1;
`ifdef KF8259_MODE_8080_EN
               vout_d  = mode_8086_q ? {vector_base, level} : {address_low_base, level, 2'b00};
`else
               vout_d  = {vector_base, level};
`endif
            end else if (ack_end) begin
               voe_d  = 1'b0;
               vout_d = '0;
            end
         end
         ACK_2: begin
`ifdef KF8259_MODE_8080_EN
            if (ack_start && !mode_8086_q) begin
               state_d = ACK_3;
               voe_d   = 1'b1;
               vout_d  = address_high;
            end else
`endif
            if (ack_end) begin
               voe_d  = 1'b0;
               vout_d = '0;
               if (mode_8086_q) begin
                  state_d   = ACK_IDLE;
                  aeoi_fire = auto_eoi_q && !spurious_q;
               end
            end
         end
`ifdef KF8259_MODE_8080_EN
         ACK_3: begin
            if (ack_end) begin
               voe_d     = 1'b0;
               vout_d    = '0;
               state_d   = ACK_IDLE;
               aeoi_fire = auto_eoi_q && !spurious_q;
            end
         end
`endif
         default: state_d = ACK_IDLE;
      endcase

      eoi_d = (aeoi_fire ? acked_q : 8'h00) | (ocw2_valid ? dec_eoi_mask : 8'h00);
      if (aeoi_fire && rot_aeoi_q) rotate_d = level;
      if (ocw2_valid) begin
         if (dec_rot_valid) rotate_d = dec_rot_value;
         if (dec_aeoi_set)  rot_aeoi_d = 1'b1;
         if (dec_aeoi_clr)  rot_aeoi_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ACK_IDLE;
         mode_8086_q <= 1'b1;
         auto_eoi_q  <= 1'b0;
         acked_q     <= '0;
         spurious_q  <= 1'b0;
         rot_aeoi_q  <= 1'b0;
         latch_q     <= 1'b0;
         intr_q      <= '0;
         eoi_q       <= '0;
         rotate_q    <= 3'b111;
         vout_q      <= '0;
         voe_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_8086_q <= mode_8086_d;
         auto_eoi_q  <= auto_eoi_d;
         acked_q     <= acked_d;
         spurious_q  <= spurious_d;
         rot_aeoi_q  <= rot_aeoi_d;
         latch_q     <= latch_d;
         intr_q      <= intr_d;
         eoi_q       <= eoi_d;
         rotate_q    <= rotate_d;
         vout_q      <= vout_d;
         voe_q       <= voe_d;
      end
   end

   assign latch_in_service = latch_q;
   assign interrupt        = intr_q;
   assign end_of_interrupt = eoi_q;
   assign priority_rotate  = rotate_q;
   assign vector_out       = vout_q;
   assign vector_oe        = voe_q;
   assign ack_busy         = (state_q != ACK_IDLE);

endmodule

// File: tb/tb_kf8259_acknowledge_control.sv
// Directed bench for kf8259_acknowledge_control; expected values are hand-computed.
module tb_kf8259_acknowledge_control;

   logic       clock = 1'b0;
   logic       reset;
   logic       ack_mode_8086;
   logic       auto_eoi;
   logic [4:0] vector_base;
   logic [2:0] address_low_base;
   logic [7:0] address_high;
   logic       ack_start;
   logic       ack_end;
   logic [7:0] interrupt_request;
   logic [7:0] highest_level_in_service;
   logic       ocw2_valid;
   logic [2:0] ocw2_cmd;
   logic [2:0] ocw2_level;
   logic       latch_in_service;
   logic [7:0] interrupt;
   logic [7:0] end_of_interrupt;
   logic [2:0] priority_rotate;
   logic [7:0] vector_out;
   logic       vector_oe;
   logic       ack_busy;

   int errs   = 0;
   int checks = 0;

   always #5 clock = ~clock;

   kf8259_acknowledge_control dut (
      .clock                    (clock),
      .reset                    (reset),
      .ack_mode_8086            (ack_mode_8086),
      .auto_eoi                 (auto_eoi),
      .vector_base              (vector_base),
      .address_low_base         (address_low_base),
      .address_high             (address_high),
      .ack_start                (ack_start),
      .ack_end                  (ack_end),
      .interrupt_request        (interrupt_request),
      .highest_level_in_service (highest_level_in_service),
      .ocw2_valid               (ocw2_valid),
      .ocw2_cmd                 (ocw2_cmd),
      .ocw2_level               (ocw2_level),
      .latch_in_service         (latch_in_service),
      .interrupt                (interrupt),
      .end_of_interrupt         (end_of_interrupt),
      .priority_rotate          (priority_rotate),
      .vector_out               (vector_out),
      .vector_oe                (vector_oe),
      .ack_busy                 (ack_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      ack_start = 1'b1;
      step();
      ack_start = 1'b0;
   endtask

   task automatic pulse_end();
      ack_end = 1'b1;
      step();
      ack_end = 1'b0;
   endtask

   task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
      ocw2_valid = 1'b1;
      ocw2_cmd   = cmd;
      ocw2_level = lvl;
      step();
      ocw2_valid = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_latch"}, 32'(latch_in_service), 32'h0);
      check({tag, "_intr"},  32'(interrupt),        32'h0);
      check({tag, "_eoi"},   32'(end_of_interrupt), 32'h0);
      check({tag, "_rot"},   32'(priority_rotate),  32'h7);
      check({tag, "_vout"},  32'(vector_out),       32'h0);
      check({tag, "_voe"},   32'(vector_oe),        32'h0);
      check({tag, "_busy"},  32'(ack_busy),         32'h0);
   endtask

   initial begin
      reset                    = 1'b0;
      ack_mode_8086            = 1'b1;
      auto_eoi                 = 1'b0;
      vector_base              = 5'h08;
      address_low_base         = 3'b101;
      address_high             = 8'h12;
      ack_start                = 1'b0;
      ack_end                  = 1'b0;
      interrupt_request        = 8'h00;
      highest_level_in_service = 8'h00;
      ocw2_valid               = 1'b0;
      ocw2_cmd                 = 3'b000;
      ocw2_level               = 3'd0;

      step();
      step();
      check_reset_outs("reset");
      reset = 1'b1;
      step();

      // 8086 sequence, request level 4
      interrupt_request = 8'h10;
      pulse_start();
      check("a86_latch", 32'(latch_in_service), 32'h1);
      check("a86_intr",  32'(interrupt),        32'h10);
      check("a86_voe1",  32'(vector_oe),        32'h0);
      check("a86_busy1", 32'(ack_busy),         32'h1);
      interrupt_request = 8'h01;
      step();
      check("a86_latch_w", 32'(latch_in_service), 32'h0);
      pulse_end();
      check("a86_busy_e1", 32'(ack_busy), 32'h1);
      pulse_start();
      check("a86_voe2",  32'(vector_oe),  32'h1);
      check("a86_vout2", 32'(vector_out), 32'h44);
      pulse_end();
      check("a86_voe_off", 32'(vector_oe),        32'h0);
      check("a86_busy_e2", 32'(ack_busy),         32'h0);
      check("a86_no_eoi",  32'(end_of_interrupt), 32'h0);

      // spurious acknowledge with AEOI enabled
      auto_eoi          = 1'b1;
      interrupt_request = 8'h00;
      pulse_start();
      check("sp_latch", 32'(latch_in_service), 32'h0);
      pulse_end();
      pulse_start();
      check("sp_vout", 32'(vector_out), 32'h47);
      check("sp_voe",  32'(vector_oe),  32'h1);
      pulse_end();
      check("sp_eoi",  32'(end_of_interrupt), 32'h0);
      check("sp_rot",  32'(priority_rotate),  32'h7);

      // AEOI with rotate enabled, level 3
      ocw2(3'b100, 3'd0);
      check("o100_eoi", 32'(end_of_interrupt), 32'h0);
      interrupt_request = 8'h08;
      pulse_start();
      pulse_end();
      pulse_start();
      pulse_end();
      check("aeoi_eoi", 32'(end_of_interrupt), 32'h08);
      check("aeoi_rot", 32'(priority_rotate),  32'h3);
      step();
      check("aeoi_eoi_w", 32'(end_of_interrupt), 32'h0);

      // rotate on non-specific EOI
      highest_level_in_service = 8'h20;
      ocw2(3'b101, 3'd0);
      check("o101_eoi", 32'(end_of_interrupt), 32'h20);
      check("o101_rot", 32'(priority_rotate),  32'h5);
      step();
      check("o101_eoi_w", 32'(end_of_interrupt), 32'h0);

      // specific EOI level 2 coincident with AEOI of level 0
      interrupt_request = 8'h01;
      pulse_start();
      pulse_end();
      pulse_start();
      ack_end    = 1'b1;
      ocw2_valid = 1'b1;
      ocw2_cmd   = 3'b011;
      ocw2_level = 3'd2;
      step();
      ack_end    = 1'b0;
      ocw2_valid = 1'b0;
      check("merge_eoi", 32'(end_of_interrupt), 32'h05);
      check("merge_rot", 32'(priority_rotate),  32'h0);

      // rotate with AEOI and an OCW2 set-priority in the same cycle: OCW2 wins
      interrupt_request = 8'h02;
      pulse_start();
      pulse_end();
      pulse_start();
      ack_end    = 1'b1;
      ocw2_valid = 1'b1;
      ocw2_cmd   = 3'b110;
      ocw2_level = 3'd4;
      step();
      ack_end    = 1'b0;
      ocw2_valid = 1'b0;
      check("win_eoi", 32'(end_of_interrupt), 32'h02);
      check("win_rot", 32'(priority_rotate),  32'h4);

      // set priority, clear AEOI rotate, other OCW2 codes
      ocw2(3'b110, 3'd3);
      check("o110_rot", 32'(priority_rotate),  32'h3);
      check("o110_eoi", 32'(end_of_interrupt), 32'h0);
      ocw2(3'b000, 3'd0);
      pulse_start();
      pulse_end();
      pulse_start();
      pulse_end();
      check("norot_eoi", 32'(end_of_interrupt), 32'h02);
      check("norot_rot", 32'(priority_rotate),  32'h3);
      highest_level_in_service = 8'h00;
      ocw2(3'b001, 3'd0);
      check("o001_zero", 32'(end_of_interrupt), 32'h0);
      ocw2(3'b101, 3'd0);
      check("o101_zero_rot", 32'(priority_rotate), 32'h3);
      ocw2(3'b010, 3'd5);
      check("o010_eoi", 32'(end_of_interrupt), 32'h0);
      check("o010_rot", 32'(priority_rotate),  32'h3);
      ocw2(3'b111, 3'd6);
      check("o111_eoi", 32'(end_of_interrupt), 32'h40);
      check("o111_rot", 32'(priority_rotate),  32'h6);

      // ack_mode_8086 = 0
      auto_eoi          = 1'b0;
      ack_mode_8086     = 1'b0;
      interrupt_request = 8'h04;
`ifdef KF8259_MODE_8080_EN
      pulse_start();
      check("a80_latch", 32'(latch_in_service), 32'h1);
      check("a80_b1",    32'(vector_out),       32'hCD);
      check("a80_voe1",  32'(vector_oe),        32'h1);
      ack_mode_8086 = 1'b1;
      pulse_end();
      check("a80_voe_e1", 32'(vector_oe), 32'h0);
      pulse_start();
      check("a80_b2", 32'(vector_out), 32'hA8);
      pulse_end();
      check("a80_busy_e2", 32'(ack_busy), 32'h1);
      pulse_start();
      check("a80_b3", 32'(vector_out), 32'h12);
      pulse_end();
      check("a80_busy_e3", 32'(ack_busy), 32'h0);
`else
      pulse_start();
      check("m0_latch", 32'(latch_in_service), 32'h1);
      check("m0_voe1",  32'(vector_oe),        32'h0);
      pulse_end();
      pulse_start();
      check("m0_vout2", 32'(vector_out), 32'h42);
      pulse_end();
      check("m0_busy", 32'(ack_busy), 32'h0);
`endif
      ack_mode_8086 = 1'b1;

      // reset in ACK2 with AEOI pending
      auto_eoi          = 1'b1;
      interrupt_request = 8'h10;
      pulse_start();
      pulse_end();
      pulse_start();
      check("rst_pre_voe", 32'(vector_oe), 32'h1);
      reset = 1'b0;
      step();
      check_reset_outs("midrst");
      reset = 1'b1;
      pulse_end();
      check("midrst_no_eoi", 32'(end_of_interrupt), 32'h0);
      check("midrst_idle",   32'(ack_busy),         32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/kf8259_acknowledge_control.md
# kf8259_acknowledge_control

Sequencer that drives the interrupt-acknowledge and end-of-interrupt side of the 8259 in-service register. It sits between the bus/control interface and the in-service register: it counts INTA pulses, freezes the winning request level, raises the one-cycle latch strobe, puts vector bytes on the data bus, and turns OCW2 commands and automatic EOI into one-hot clear masks and priority-rotation updates.

## Interface
Parameters:
- none; all encodings live in `kf8259_pkg`.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `ack_mode_8086`  in  1  ICW4 uPM: 1 = two-pulse 8086 sequence, 0 = three-pulse 8080 sequence
- `auto_eoi`  in  1  ICW4 AEOI
- `vector_base`  in  5  ICW2 T7..T3 (8086 vector)
- `address_low_base`  in  3  ICW1 A7..A5 (8080, interval 4)
- `address_high`  in  8  ICW2 A15..A8 (8080)
- `ack_start`  in  1  one-cycle strobe, INTA leading (falling) edge, pre-synchronized
- `ack_end`  in  1  one-cycle strobe, INTA trailing (rising) edge
- `interrupt_request`  in  8  one-hot winning request from the priority resolver; 0 = none
- `highest_level_in_service`  in  8  one-hot highest in-service level
- `ocw2_valid`  in  1  one-cycle OCW2 write strobe
- `ocw2_cmd`  in  3  OCW2 {R, SL, EOI}
- `ocw2_level`  in  3  OCW2 L2..L0
- `latch_in_service`  out  1  one-cycle set strobe to the in-service register
- `interrupt`  out  8  one-hot acknowledged level; valid while `latch_in_service`=1
- `end_of_interrupt`  out  8  one-cycle one-hot clear mask
- `priority_rotate`  out  3  current lowest-priority level
- `vector_out`  out  8  byte for the data bus
- `vector_oe`  out  1  drive enable for `vector_out`
- `ack_busy`  out  1  acknowledge sequence in progress

## Operation
- States: IDLE, ACK1, ACK2, ACK3. ACK3 exists only in 8080 mode.
- IDLE + `ack_start`:
  - → ACK1.
  - Capture `interrupt_request` into `acked_level`.
  - If the capture is 0, the acknowledge is spurious: level 7 is used and `latch_in_service` is not raised.
  - Otherwise `latch_in_service`=1 for one cycle, with `interrupt`=captured one-hot.
- Each later `ack_start` advances ACK1→ACK2, then ACK2→ACK3 (8080 only).
- `ack_end` in the final state (ACK2 for 8086, ACK3 for 8080) → IDLE. `ack_end` in any other state is ignored, as is `ack_start` beyond the final state.
- Data bus, only while a pulse is active (`ack_start` seen, `ack_end` not yet):
  - 8086, ACK1: `vector_oe`=0.
  - 8086, ACK2: `vector_out`={`vector_base`, level}.
  - 8080, ACK1: 8'hCD.
  - 8080, ACK2: {`address_low_base`, level, 2'b00}.
  - 8080, ACK3: `address_high`.
- AEOI: at the final `ack_end` of a non-spurious sequence, `end_of_interrupt`=acked one-hot. If `rotate_in_aeoi`=1, also `priority_rotate`←level.
- OCW2 decode, {R,SL,EOI}:
  - 001 non-specific EOI: clear `highest_level_in_service`; no-op if it is 0.
  - 011 specific EOI: clear 1<<`ocw2_level`.
  - 101: non-specific EOI plus rotate to the cleared level.
  - 111: specific EOI plus rotate to `ocw2_level`.
  - 110 set priority: `priority_rotate`←`ocw2_level`.
  - 100: `rotate_in_aeoi`←1.
  - 000: `rotate_in_aeoi`←0.
  - 010: no-op.
- Simultaneous AEOI and OCW2 in one cycle: `end_of_interrupt` is the OR of both masks. For the rotate update, OCW2 wins.
- Mode inputs are sampled at the first `ack_start` and held for the rest of the sequence.

## Timing
- All outputs are registered. A strobe in cycle N produces its response in cycle N+1. The in-service register therefore updates at N+2.
- `latch_in_service` and `end_of_interrupt` are exactly one cycle wide.
- `vector_oe` rises at N+1 after `ack_start` and falls at N+1 after `ack_end`.
- Reset values:
  - state IDLE, `rotate_in_aeoi`=0
  - `latch_in_service`=0, `interrupt`=0, `end_of_interrupt`=0
  - `priority_rotate`=3'b111
  - `vector_out`=0, `vector_oe`=0, `ack_busy`=0
- Reset in mid-sequence returns to IDLE with no AEOI pulse.

## Configuration
- `KF8259_MODE_8080_EN` defined: 8080 three-pulse sequence and ACK3 are supported.
- `KF8259_MODE_8080_EN` undefined: `ack_mode_8086` is ignored and treated as 1, and ACK3 and the 8080 byte mux are removed.

## Structure
- `kf8259_pkg` holds:
  - the ack-state enum
  - OCW2 command localparams
  - CALL opcode 8'hCD
  - onehot-to-index and index-to-onehot functions
- Sub-module `kf8259_ocw2_decoder` (combinational): maps {cmd, level, highest in-service} to {eoi mask, rotate-valid, rotate value, aeoi-rotate set/clear}.

## Test plan
- 8086 mode, `vector_base`=5'h08, request 8'h10 → `latch_in_service` pulse with `interrupt`=8'h10; second pulse `vector_out`=8'h44.
- 8080 mode, `address_low_base`=3'b101, `address_high`=8'h12, request 8'h04 → bytes 8'hCD, 8'hA8, 8'h12.
- Spurious: request 0 during 8086 ack → no `latch_in_service`, vector {`vector_base`,3'd7}, no AEOI clear.
- AEOI with rotate set (OCW2 100), request 8'h08 → `end_of_interrupt`=8'h08 one cycle after final `ack_end`, then `priority_rotate`=3.
- OCW2 101 with `highest_level_in_service`=8'h20 → `end_of_interrupt`=8'h20, `priority_rotate`=5; OCW2 011 level 2 in the same cycle as AEOI of 8'h01 → `end_of_interrupt`=8'h05.
- Reset asserted in ACK2 → next cycle all outputs at reset values, `priority_rotate`=7.
